// File: rtl/five_stage_adder_if.sv
// five_stage_adder_if: operand/result bundle for the pipelined adder.
// The producer (master) drives valid_i/data_1/data_2.
// The adder (slave) drives data_out/valid_o.
interface five_stage_adder_if #(
    parameter int DATA_W = 16
);
    logic              valid_i;
    logic [DATA_W-1:0] data_1;
    logic [DATA_W-1:0] data_2;
    logic [DATA_W:0]   data_out;
    logic              valid_o;

    modport master (
        output valid_i, data_1, data_2,
        input  data_out, valid_o
    );

    modport slave (
        input  valid_i, data_1, data_2,
        output data_out, valid_o
    );
endinterface

// File: rtl/five_stage_adder.sv
// five_stage_adder: 16-bit unsigned adder, 17-bit result, 5-cycle latency.
// The carry chain is cut into 4-bit slices, with one slice per pipeline stage.
// Data registers advance every cycle, and valid travels alongside as a tag.
// Optional build macro FIVE_STAGE_ADDER_HOLD_EN:
//   - defined: data_out holds the last valid sum during bubbles.
//   - undefined: data_out reads 0 whenever valid_o is low.
module five_stage_adder #(
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    five_stage_adder_if.slave  bus
);
    localparam int STAGES = 5;

    // Valid tags: bit 0 is S1, bit STAGES-1 is the output stage.
    logic [STAGES-1:0] vld_pipe;

    // S1 operands
    logic [DATA_W-1:0]  a1, b1;
    // S2: low slice done
    logic [3:0]         sum2;
    logic               c2;
    logic [DATA_W-1:4]  a2, b2;
    // S3: two slices done
    logic [7:0]         sum3;
    logic               c3;
    logic [DATA_W-1:8]  a3, b3;
    // S4: three slices done
    logic [11:0]        sum4;
    logic               c4;
    logic [DATA_W-1:12] a4, b4;
    // S5: registered output
    logic [DATA_W:0]    data_out_q;

    // One 4-bit slice add per stage; the carry-in comes from the previous stage's register.
    logic [4:0] slc2, slc3, slc4, slc5;
    assign slc2 = {1'b0, a1[3:0]}   + {1'b0, b1[3:0]};
    assign slc3 = {1'b0, a2[7:4]}   + {1'b0, b2[7:4]}   + {4'b0, c2};
    assign slc4 = {1'b0, a3[11:8]}  + {1'b0, b3[11:8]}  + {4'b0, c3};
    assign slc5 = {1'b0, a4[15:12]} + {1'b0, b4[15:12]} + {4'b0, c4};

    // Shift the valid tag along with the data; reset drops all in-flight pairs.
    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-2:0], bus.valid_i};
    end

    // Operand and partial-sum pipeline, advancing unconditionally.
    always_ff @(posedge clk) begin
        if (rst) begin
            a1 <= '0; b1 <= '0;
            sum2 <= '0; c2 <= 1'b0; a2 <= '0; b2 <= '0;
            sum3 <= '0; c3 <= 1'b0; a3 <= '0; b3 <= '0;
            sum4 <= '0; c4 <= 1'b0; a4 <= '0; b4 <= '0;
        end else begin
            a1   <= bus.data_1;
            b1   <= bus.data_2;
            sum2 <= slc2[3:0];
            c2   <= slc2[4];
            a2   <= a1[DATA_W-1:4];
            b2   <= b1[DATA_W-1:4];
            sum3 <= {slc3[3:0], sum2};
            c3   <= slc3[4];
            a3   <= a2[DATA_W-1:8];
            b3   <= b2[DATA_W-1:8];
            sum4 <= {slc4[3:0], sum3};
            c4   <= slc4[4];
            a4   <= a3[DATA_W-1:12];
            b4   <= b3[DATA_W-1:12];
        end
    end

`ifdef FIVE_STAGE_ADDER_HOLD_EN
    // Output stage: capture only valid sums; bubbles keep the last result.
    always_ff @(posedge clk) begin
        if (rst)              data_out_q <= '0;
        else if (vld_pipe[3]) data_out_q <= {slc5, sum4};
    end
`else
    // Output stage: data_out is zero unless the result is valid.
    always_ff @(posedge clk) begin
        if (rst)              data_out_q <= '0;
        else if (vld_pipe[3]) data_out_q <= {slc5, sum4};
        else                  data_out_q <= '0;
    end
`endif

    assign bus.data_out = data_out_q;
    assign bus.valid_o  = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_five_stage_adder.sv
// tb_five_stage_adder: scoreboard bench for five_stage_adder.
// The driver pushes expected sums as pairs are issued.
// The monitor pops and compares them whenever valid_o is high.
module tb_five_stage_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    five_stage_adder_if #(.DATA_W(16)) bus ();

    five_stage_adder #(.DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [16:0] sum;
        int          issue;
    } exp_t;

    exp_t        sb[$];
    int          n_chk    = 0;
    int          n_fail   = 0;
    logic [16:0] last_sum = '0;
    bit          started  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one input slot at a negedge; it is sampled at the next rising edge.
    task automatic send(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic [16:0] exp);
        exp_t e;
        @(negedge clk);
        bus.valid_i = v;
        bus.data_1  = a;
        bus.data_2  = b;
        if (v) begin
            e.sum   = exp;
            e.issue = cyc + 1;
            sb.push_back(e);
        end
    endtask

    // One-cycle reset, optionally with a valid pair in the same slot, which must be dropped.
    task automatic do_reset(input logic v, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst         = 1'b1;
        bus.valid_i = v;
        bus.data_1  = a;
        bus.data_2  = b;
        @(posedge clk);
        #1;
        sb.delete();
        last_sum    = '0;
        rst         = 1'b0;
        bus.valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 16'hDEAD, 16'hBEEF, '0);
    endtask

    // Monitor: check ordered results, latency, and data_out during bubbles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                if (bus.valid_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", {15'b0, bus.data_out}, 32'h0);
                        if (bus.data_out == '0) begin
                            n_fail++;
                            $display("FAIL unexpected_valid: got valid_o=1 expected valid_o=0 (cycle %0d)", cyc);
                        end
                    end else begin
                        e = sb.pop_front();
                        chk("sum", {15'b0, bus.data_out}, {15'b0, e.sum});
                        chk("latency", cyc - e.issue, 32'd4);
                        last_sum = e.sum;
                    end
                end else begin
`ifdef FIVE_STAGE_ADDER_HOLD_EN
                    chk("bubble_hold", {15'b0, bus.data_out}, {15'b0, last_sum});
`else
                    chk("bubble_zero", {15'b0, bus.data_out}, 32'h0);
`endif
                    if (sb.size() > 0 && (cyc - sb[0].issue) >= 4) begin
                        e = sb.pop_front();
                        n_chk++;
                        n_fail++;
                        $display("FAIL missing_valid: got valid_o=0 expected sum %h (cycle %0d)", e.sum, cyc);
                    end
                end
            end
        end
    end

    initial begin
        logic        v;
        logic [15:0] a, b;
        bus.valid_i = 1'b0;
        bus.data_1  = '0;
        bus.data_2  = '0;
        repeat (3) @(posedge clk);
        do_reset(1'b0, '0, '0);
        @(negedge clk);
        chk("reset_valid_o", {31'b0, bus.valid_o}, 32'h0);
        chk("reset_data_out", {15'b0, bus.data_out}, 32'h0);
        started = 1;

        // Back-to-back small sums.
        send(1'b1, 16'h0002, 16'h0003, 17'h00005);
        send(1'b1, 16'h0004, 16'h0005, 17'h00009);
        send(1'b1, 16'h0007, 16'h0008, 17'h0000F);
        idle(8);

        // Carry ripple through all slices.
        send(1'b1, 16'hFFFF, 16'h0001, 17'h10000);
        send(1'b1, 16'hFFFF, 16'hFFFF, 17'h1FFFE);
        send(1'b1, 16'h0FFF, 16'h0001, 17'h01000);
        send(1'b1, 16'h00F0, 16'h0010, 17'h00100);
        idle(8);

        // Bubble in the middle with junk operands.
        send(1'b1, 16'h1234, 16'h1111, 17'h02345);
        send(1'b0, 16'hFFFF, 16'hFFFF, '0);
        send(1'b1, 16'h8000, 16'h8000, 17'h10000);
        idle(8);

        // Reset with three pairs in flight.
        send(1'b1, 16'h1111, 16'h2222, 17'h03333);
        send(1'b1, 16'h3333, 16'h4444, 17'h07777);
        send(1'b1, 16'h5555, 16'h6666, 17'h0BBBB);
        do_reset(1'b0, '0, '0);
        send(1'b1, 16'h0001, 16'h0001, 17'h00002);
        idle(8);

        // Reset and valid in the same slot: the pair must not appear.
        do_reset(1'b1, 16'h0005, 16'h0005);
        idle(8);
        send(1'b1, 16'hABCD, 16'h1234, 17'h0BE01);
        idle(8);

        // Random pairs with random valid.
        for (int i = 0; i < 1000; i++) begin
            v = ($urandom_range(0, 99) < 70);
            a = 16'($urandom);
            b = 16'($urandom);
            send(v, a, b, {1'b0, a} + {1'b0, b});
        end
        idle(10);

        chk("drain_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/five_stage_adder.md
# five_stage_adder

Pipelined unsigned adder: two DATA_W-bit operands in, a DATA_W+1-bit sum out, exactly 5 clock cycles later. The carry chain is split into 4-bit slices across pipeline stages, so each stage has a short critical path. It accepts one operand pair per cycle with no back-pressure. It sits on a datapath where the producer qualifies data with a valid strobe and the consumer samples on `valid_o`.

## Interface
- DATA_W, 16, operand width; must be 16 (four 4-bit slices); other values are unsupported.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  operand pair on data_1/data_2 is valid this cycle.
- data_1  input  DATA_W  unsigned operand A.
- data_2  input  DATA_W  unsigned operand B.
- data_out  output  DATA_W+1  unsigned sum A+B; bit DATA_W is carry-out.
- valid_o  output  1  data_out holds a valid result this cycle.

## Operation
- Reset is synchronous and active-high: rst sampled high at a rising edge clears every stage valid bit, all operand/partial-sum registers, data_out and valid_o to 0.
- S1: register data_1, data_2, valid_i unconditionally each cycle.
- S2: sum bits [3:0] = A[3:0]+B[3:0]; register 4-bit partial sum, slice carry, remaining operand bits [15:4], valid.
- S3: bits [7:4] plus S2 carry; append to partial sum; forward carry, operand bits [15:8], valid.
- S4: bits [11:8] plus S3 carry; forward carry, operand bits [15:12], valid.
- S5: bits [15:12] plus S4 carry; final carry becomes data_out[16]; register into data_out/valid_o.
- Arithmetic is unsigned modulo nothing: full 17-bit result, no overflow flag, no saturation.
- Data registers advance every cycle regardless of valid (valid is a side-band tag); no stall or flush input.
- valid_i may be high any number of consecutive cycles; bubbles (valid_i low) propagate as valid_o low in the same relative slot.
- data_1/data_2 with valid_i low are don't-care; they must never cause valid_o high.

## Timing
- Latency: pair sampled at rising edge N appears on data_out with valid_o=1 after rising edge N+4 (fifth register stage), i.e. stable during cycle N+4..N+5.
- Throughput: one result per cycle; back-to-back inputs give back-to-back outputs in order.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset mid-operation: all in-flight pairs discarded; valid_o low from the cycle after the reset edge until 5 cycles after the first post-reset valid_i.
- valid_i and rst high together: rst wins; pair is dropped.
- Outputs before first valid result after reset: data_out=0, valid_o=0.

## Configuration
- FIVE_STAGE_ADDER_HOLD_EN defined: S5 updates data_out only when stage-5 valid is 1; during bubbles data_out holds the last valid sum (0 after reset) while valid_o=0.
- Not defined: data_out is forced to 0 whenever valid_o=0; data_out nonzero only alongside valid_o=1.
- valid_o timing is identical in both builds.

## Test plan
- Reset then back-to-back 0x0002+0x0003, 0x0004+0x0005, 0x0007+0x0008 at edges 1,2,3 -> valid_o high edges 5,6,7 with data_out 0x00005, 0x00009, 0x0000F; low afterwards.
- Carry ripple across all slices: 0xFFFF+0x0001 -> 0x10000; 0xFFFF+0xFFFF -> 0x1FFFE; 0x0FFF+0x0001 -> 0x01000.
- Bubble pattern valid_i 1,0,1 with 0x1234+0x1111, junk, 0x8000+0x8000 -> valid_o 1,0,1 with 0x02345, (0x02345 if HOLD_EN else 0), 0x10000.
- Reset asserted for one cycle with 3 pairs in flight -> valid_o stays 0 for those pairs, data_out=0; next pair 0x0001+0x0001 yields 0x00002 exactly 5 cycles later.
- rst and valid_i high same edge with 0x0005+0x0005 -> no valid_o for that pair.
- Random 1000 pairs with random valid -> every valid_o matches golden A+B in order, latency always 5.
